// File: rtl/core_pkg.sv
// core_pkg: immediate-source selector encodings shared by the decoder and the extender
package core_pkg;
  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_NONE  = 3'b111;
endpackage

// File: rtl/imm_ext_comb.sv
// imm_ext_comb: combinational RISC-V immediate extender; instr_i[k]=instr[k+7], imm_o is XLEN wide, shamt_err_o flags shamt bit 5 on RV32
module imm_ext_comb import core_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr_i,
  input  logic [2:0]      immsrc_i,
  output logic [XLEN-1:0] imm_o,
  output logic            shamt_err_o
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_ext_comb: XLEN must be 32 or 64");
  end
  always_comb begin
    imm_o = immsrc_i == IMM_I     ? XLEN'($signed(instr_i[24:13])) :
            immsrc_i == IMM_S     ? XLEN'($signed({instr_i[24:18], instr_i[4:0]})) :
            immsrc_i == IMM_B     ? XLEN'($signed({instr_i[24], instr_i[0], instr_i[23:18], instr_i[4:1], 1'b0})) :
            immsrc_i == IMM_J     ? XLEN'($signed({instr_i[24], instr_i[12:5], instr_i[13], instr_i[23:14], 1'b0})) :
            immsrc_i == IMM_U     ? XLEN'($signed({instr_i[24:5], 12'b0})) :
            immsrc_i == IMM_SHAMT ? (XLEN == 32 ? XLEN'(instr_i[17:13]) : XLEN'(instr_i[18:13])) :
            immsrc_i == IMM_ZIMM  ? XLEN'(instr_i[12:8]) :
                                    '0;
    shamt_err_o = immsrc_i == IMM_SHAMT && XLEN == 32 && instr_i[18];
  end
endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: registered immediate generator with valid/ready handshake and 2-entry skid FIFO; ports: in_* upstream, out_*/imm_out/tag_out/shamt_err downstream, flush discards held entries
module imm_ext_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             shamt_err
);
  logic [XLEN-1:0]  ext_imm, main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
  logic             ext_err, main_err_q, main_err_d, skid_err_q, skid_err_d;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic             accept, pop, from_skid, load_main, load_skid;
  imm_ext_comb #(.XLEN(XLEN)) u_ext (
    .instr_i    (in_instr),
    .immsrc_i   (in_immsrc),
    .imm_o      (ext_imm),
    .shamt_err_o(ext_err)
  );
  assign in_ready  = ~rst & ~skid_v_q;
  assign out_valid = main_v_q;
  assign imm_out   = main_imm_q;
  assign tag_out   = main_tag_q;
  assign shamt_err = main_err_q;
  assign accept    = in_valid & in_ready;
  assign pop       = main_v_q & out_ready;
  // accept is blocked while skid is occupied, so a skid refill never races a new entry
  assign from_skid = pop & skid_v_q;
  assign load_main = accept & (~main_v_q | pop);
  assign load_skid = accept & main_v_q & ~pop;
  always_comb begin
    main_imm_d = from_skid ? skid_imm_q : load_main ? ext_imm : main_imm_q;
    main_tag_d = from_skid ? skid_tag_q : load_main ? in_tag  : main_tag_q;
    main_err_d = from_skid ? skid_err_q : load_main ? ext_err : main_err_q;
    main_v_d   = from_skid | load_main | (main_v_q & ~pop);
    skid_imm_d = load_skid ? ext_imm : skid_imm_q;
    skid_tag_d = load_skid ? in_tag  : skid_tag_q;
    skid_err_d = load_skid ? ext_err : skid_err_q;
    skid_v_d   = load_skid | (skid_v_q & ~pop);
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_err_q <= 1'b0;
      main_v_q   <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
      skid_v_q   <= 1'b0;
    end else begin
      main_imm_q <= main_imm_d;
      main_tag_q <= main_tag_d;
      main_err_q <= main_err_d;
      main_v_q   <= main_v_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_err_q <= skid_err_d;
      skid_v_q   <= skid_v_d;
    end
  end
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed self-checking bench for imm_ext_stage at XLEN=32 and XLEN=64
module tb_imm_ext_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [24:0] in_instr;
  logic [2:0]  in_immsrc;
  logic [4:0]  in_tag;
  logic        r32, v32, e32, r64, v64, e64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;
  int          vectors = 0;
  int          errs = 0;
  always #5 clk = ~clk;
  imm_ext_stage #(.XLEN(32), .TAG_W(5)) d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr),
    .in_immsrc(in_immsrc), .in_tag(in_tag), .flush(flush), .out_valid(v32),
    .out_ready(out_ready), .imm_out(imm32), .tag_out(tag32), .shamt_err(e32)
  );
  imm_ext_stage #(.XLEN(64), .TAG_W(5)) d64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr),
    .in_immsrc(in_immsrc), .in_tag(in_tag), .flush(flush), .out_valid(v64),
    .out_ready(out_ready), .imm_out(imm64), .tag_out(tag64), .shamt_err(e64)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] ins, input logic [2:0] m, input logic [4:0] t);
    in_valid  = 1'b1;
    in_instr  = ins[31:7];
    in_immsrc = m;
    in_tag    = t;
  endtask
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_immsrc = '0; in_tag = '0;
    step();
    step();
    vectors++;
    if (v32 !== 1'b0 || v64 !== 1'b0 || r32 !== 1'b0 || r64 !== 1'b0) begin
      errs++; $display("FAIL reset_flags: v32=%b v64=%b r32=%b r64=%b, required all 0", v32, v64, r32, r64);
    end
    vectors++;
    if (imm32 !== 32'h0 || imm64 !== 64'h0 || tag32 !== 5'h0 || e32 !== 1'b0) begin
      errs++; $display("FAIL reset_data: imm32=%h imm64=%h tag=%h err=%b, required 0", imm32, imm64, tag32, e32);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (r32 !== 1'b1) begin
      errs++; $display("FAIL reset_release_ready: in_ready=%b, required 1", r32);
    end
  endtask
  task automatic test_i_s();
    out_ready = 1'b1;
    drive(32'hFFF00093, 3'b000, 5'd1);
    step();
    vectors++;
    if (v32 !== 1'b1 || imm32 !== 32'hFFFFFFFF || tag32 !== 5'd1) begin
      errs++; $display("FAIL i_imm: valid=%b imm=%h tag=%0d, required 1 ffffffff 1", v32, imm32, tag32);
    end
    drive(32'hFE112E23, 3'b001, 5'd2);
    step();
    in_valid = 1'b0;
    vectors++;
    if (v32 !== 1'b1 || imm32 !== 32'hFFFFFFFC || tag32 !== 5'd2 || imm64 !== 64'hFFFFFFFFFFFFFFFC) begin
      errs++; $display("FAIL s_imm: valid=%b imm32=%h tag=%0d imm64=%h, required 1 fffffffc 2 fffffffffffffffc", v32, imm32, tag32, imm64);
    end
    step();
    vectors++;
    if (v32 !== 1'b0) begin
      errs++; $display("FAIL i_s_drain: out_valid=%b, required 0", v32);
    end
  endtask
  task automatic test_bju();
    logic [31:0] ins [5] = '{32'hFE000CE3, 32'h0010006F, 32'h123452B7, 32'h800002B7, 32'hFFFFFFFF};
    logic [2:0]  md  [5] = '{3'b010, 3'b011, 3'b100, 3'b100, 3'b111};
    logic [31:0] x32 [5] = '{32'hFFFFFFF8, 32'h00000800, 32'h12345000, 32'h80000000, 32'h0};
    logic [63:0] x64 [5] = '{64'hFFFFFFFFFFFFFFF8, 64'h800, 64'h12345000, 64'hFFFFFFFF80000000, 64'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(ins[i], md[i], 5'(i + 3));
      step();
      in_valid = 1'b0;
      vectors++;
      if (v32 !== 1'b1 || imm32 !== x32[i] || imm64 !== x64[i]) begin
        errs++; $display("FAIL bju_%0d: valid=%b imm32=%h imm64=%h, required 1 %h %h", i, v32, imm32, imm64, x32[i], x64[i]);
      end
      step();
    end
  endtask
  task automatic test_shamt_zimm();
    logic [31:0] ins [3] = '{32'h02009093, 32'h000FD073, 32'h41F0D093};
    logic [2:0]  md  [3] = '{3'b101, 3'b110, 3'b101};
    logic [31:0] x32 [3] = '{32'h0, 32'h1F, 32'h1F};
    logic        xe  [3] = '{1'b1, 1'b0, 1'b0};
    logic [63:0] x64 [3] = '{64'h20, 64'h1F, 64'h1F};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ins[i], md[i], 5'd0);
      step();
      in_valid = 1'b0;
      vectors++;
      if (imm32 !== x32[i] || e32 !== xe[i] || imm64 !== x64[i] || e64 !== 1'b0) begin
        errs++; $display("FAIL shamt_zimm_%0d: imm32=%h err32=%b imm64=%h err64=%b, required %h %b %h 0", i, imm32, e32, imm64, e64, x32[i], xe[i], x64[i]);
      end
      step();
    end
  endtask
  task automatic test_back_to_back();
    int next_tag = 1;
    int exp_tag = 1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(32'h00000013, 3'b000, 5'(next_tag));
      if (r32) next_tag++;
      step();
    end
    vectors++;
    if (r32 !== 1'b0 || next_tag !== 3 || tag32 !== 5'd1 || v32 !== 1'b1) begin
      errs++; $display("FAIL backpressure_hold: in_ready=%b accepts=%0d tag=%0d valid=%b, required 0 2 1 1", r32, next_tag - 1, tag32, v32);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_tag <= 4; c++) begin
      if (next_tag <= 4) drive(32'h00000013, 3'b000, 5'(next_tag));
      else in_valid = 1'b0;
      if (in_valid && r32) next_tag++;
      if (v32) begin
        vectors++;
        if (tag32 !== 5'(exp_tag)) begin
          errs++; $display("FAIL order_%0d: tag_out=%0d, required %0d", exp_tag, tag32, exp_tag);
        end
        exp_tag++;
      end
      step();
    end
    in_valid = 1'b0;
    vectors++;
    if (exp_tag !== 5 || v32 !== 1'b0) begin
      errs++; $display("FAIL order_complete: popped=%0d valid=%b, required 4 0", exp_tag - 1, v32);
    end
  endtask
  task automatic fill_two();
    out_ready = 1'b0;
    drive(32'h123452B7, 3'b100, 5'd5);
    step();
    drive(32'hFFF00093, 3'b000, 5'd6);
    step();
  endtask
  task automatic test_flush();
    fill_two();
    vectors++;
    if (r32 !== 1'b0 || v32 !== 1'b1) begin
      errs++; $display("FAIL flush_setup: in_ready=%b valid=%b, required 0 1", r32, v32);
    end
    drive(32'h0010006F, 3'b011, 5'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (v32 !== 1'b0 || r32 !== 1'b1 || v64 !== 1'b0) begin
      errs++; $display("FAIL flush_clear: valid=%b in_ready=%b, required 0 1", v32, r32);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (v32 !== 1'b0) begin
      errs++; $display("FAIL flush_drop: valid=%b tag=%0d, required valid 0", v32, tag32);
    end
  endtask
  task automatic test_reset_midstream();
    fill_two();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    vectors++;
    if (v32 !== 1'b0 || imm32 !== 32'h0 || tag32 !== 5'd0 || r32 !== 1'b0) begin
      errs++; $display("FAIL reset_mid: valid=%b imm=%h tag=%0d in_ready=%b, required 0 0 0 0", v32, imm32, tag32, r32);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    drive(32'h123452B7, 3'b100, 5'd9);
    step();
    in_valid = 1'b0;
    vectors++;
    if (v32 !== 1'b1 || imm32 !== 32'h12345000 || tag32 !== 5'd9) begin
      errs++; $display("FAIL reset_first_accept: valid=%b imm=%h tag=%0d, required 1 12345000 9", v32, imm32, tag32);
    end
    step();
  endtask
  initial begin
    test_reset();
    test_i_s();
    test_bju();
    test_shamt_zimm();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
Registered, parametrised immediate generator for the pipelined RISC-V core, placed at the ID/EX boundary. It takes instruction bits [31:7] and an immediate-source selector and produces a sign- or zero-extended XLEN-bit immediate one cycle later. A valid/ready handshake with a 2-entry skid buffer gives full throughput under back-pressure. Over the single-cycle extender it adds RV64 width, shift-amount and CSR-zimm modes, an illegal-shamt flag, flush, and a sideband tag.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
TAG_W, 5, width of the sideband tag carried alongside the immediate (e.g. rd index)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  25  instruction bits [31:7]; in_instr[k] = instr[k+7]
in_immsrc  in  3  immediate mode select
in_tag  in  TAG_W  sideband, passed through unchanged
flush  in  1  discard all held entries
out_valid  out  1  imm_out/tag_out/shamt_err are valid
out_ready  in  1  downstream accepts this cycle
imm_out  out  XLEN  extended immediate
tag_out  out  TAG_W  tag of the presented entry
shamt_err  out  1  shamt-mode entry used instr[25]=1 while XLEN=32

Behaviour:
- Modes (s = instr[31], sign-extended to XLEN unless noted):
  - 000 I: instr[31:20]
  - 001 S: {instr[31:25], instr[11:7]}
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - 100 U: {instr[31:12], 12'b0}; sign-extended from bit 31 when XLEN=64
  - 101 SHAMT: zero-extended. XLEN=32: instr[24:20], shamt_err=instr[25]. XLEN=64: instr[25:20], shamt_err=0
  - 110 ZIMM: zero-extended instr[19:15]
  - 111: all zeros
- Extension is combinational on the inputs. The result is captured at accept.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Latency: 1 cycle. An entry accepted at edge N is presented from edge N+1.
- Storage is a main register plus a skid register, with order preserved (FIFO).
  - Accept with main empty, or main popping the same cycle and skid empty: write main.
  - Accept with main full and not popping: write skid.
  - Pop with skid full: skid moves to main.
- in_ready = ~rst & ~skid_valid. It deasserts only while the skid is occupied.
- out_valid = main_valid. Outputs hold stable while out_valid & ~out_ready.
- flush: at the next edge both entries are invalidated. flush takes priority over a same-cycle accept, which is dropped. flush with both empty is a no-op.
- Reset, synchronous: main_valid=0, skid_valid=0, imm_out=0, tag_out=0, shamt_err=0, out_valid=0, in_ready=0 while rst=1.
  - Asserting rst mid-stream discards held entries exactly like flush.
- Simultaneous accept and pop with 1 entry held: occupancy stays 1 and the new entry becomes main.
- Undefined XLEN (not 32/64): elaboration error.

Decomposition:
- Shared package core_pkg holds localparams IMM_I=3'b000, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_ZIMM, IMM_NONE, reused by the control decoder.
- One combinational sub-module, imm_ext_comb (XLEN parameter), is the generalised extender.
- imm_ext_stage instantiates imm_ext_comb and owns the skid/handshake logic.

Test Plan:
- I/S, XLEN=32, out_ready=1: in_instr=0xFFF00093>>7 mode 000, then 0xFE112E23>>7 mode 001 on consecutive cycles -> imm_out=0xFFFFFFFF then 0xFFFFFFFC, 1 cycle later, out_valid continuous.
- B/J/U: 0xFE000CE3 (010) -> 0xFFFFFFF8; 0x0010006F (011) -> 0x00000800; 0x123452B7 (100) -> 0x12345000. XLEN=64 with 0x800002B7 (100) -> 0xFFFFFFFF80000000.
- SHAMT/ZIMM, XLEN=32: slli instr 0x02009093 (101) -> imm=0, shamt_err=1; csrrwi zimm=0x1F (110) -> 0x1F. XLEN=64 same slli -> imm=0x20, shamt_err=0.
- Back-pressure: in_valid=1 with tags 1,2,3,4 each cycle, out_ready=0 for 3 cycles -> in_ready low after 2 accepts, tag_out holds 1. Then out_ready=1 -> tags 1,2,3,4 in order, no loss or duplication.
- Flush: 2 entries held plus in_valid=1 with flush=1 -> next cycle out_valid=0, in_ready=1, the incoming entry is not presented.
- Reset mid-stream: rst=1 for 1 cycle with 2 entries held -> out_valid=0, imm_out=0, tag_out=0. First post-reset accept appears 1 cycle later.
